// File: rtl/sr_cmd_arbiter_if.sv
// Requester-side command bus of the SR bank arbiter: per-requester valid/op/idx
// with a one-hot accept strobe back from the arbiter.
interface sr_cmd_arbiter_if #(
    parameter int NREQ  = 4,
    parameter int IDX_W = 3
) ();
    logic [NREQ-1:0]       req_valid;
    logic [2*NREQ-1:0]     req_op;
    logic [IDX_W*NREQ-1:0] req_idx;
    logic [NREQ-1:0]       req_ready;

    modport master (
        output req_valid,
        output req_op,
        output req_idx,
        input  req_ready
    );

    modport slave (
        input  req_valid,
        input  req_op,
        input  req_idx,
        output req_ready
    );
endinterface

// File: rtl/sr_cmd_arbiter.sv
// Round-robin arbiter that turns set/reset/toggle commands from NREQ requesters
// into clean one-hot S/R pulses for a bank of NBITS SR flip-flops.
module sr_cmd_arbiter #(
    parameter int NREQ  = 4,
    parameter int NBITS = 8,
    parameter int IDX_W = 3,
    parameter int HOLD  = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    sr_cmd_arbiter_if.slave     req_if,
    input  logic [NBITS-1:0]    q_fb,
    output logic [NBITS-1:0]    s_out,
    output logic [NBITS-1:0]    r_out,
    output logic                busy,
    output logic [2:0]          grant_id,
    output logic                err
);
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    state_t           r_state, w_state_nxt;
    logic [NBITS-1:0] r_s, w_s_nxt;
    logic [NBITS-1:0] r_r, w_r_nxt;
    logic [3:0]       r_cnt, w_cnt_nxt;
    logic [2:0]       r_ptr, w_ptr_nxt;
    logic [2:0]       r_grant, w_grant_nxt;
    logic             r_err, w_err_nxt;
    logic             r_busy, w_busy_nxt;

    logic             w_any;
    logic [2:0]       w_win;
    int               w_j;
    logic [1:0]       w_op;
    logic [IDX_W-1:0] w_idx;
    logic [NBITS-1:0] w_onehot;
    logic             w_qbit;
    logic             w_bad;
    logic [NREQ-1:0]  w_ready;

    // Round-robin search: first valid requester at or after the pointer.
    always_comb begin
        w_any = 1'b0;
        w_win = 3'd0;
        w_j   = 0;
        for (int k = 0; k < NREQ; k++) begin
            w_j = (int'(r_ptr) + k) % NREQ;
            if (!w_any && (|(req_if.req_valid & (NREQ'(1'b1) << w_j)))) begin
                w_any = 1'b1;
                w_win = 3'(w_j);
            end else begin
                w_any = w_any;
            end
        end
    end

    assign w_op     = 2'(req_if.req_op >> (2 * int'(w_win)));
    assign w_idx    = IDX_W'(req_if.req_idx >> (IDX_W * int'(w_win)));
    // Shifting past the top yields zero, so an out-of-range idx reads q as 0.
    assign w_onehot = NBITS'(1'b1) << w_idx;
    assign w_qbit   = |(q_fb & w_onehot);
    assign w_bad    = (w_op == 2'b00) || (int'(w_idx) >= NBITS);

    // Next-state, next-output and accept-strobe logic.
    always_comb begin
        w_state_nxt = r_state;
        w_s_nxt     = r_s;
        w_r_nxt     = r_r;
        w_cnt_nxt   = r_cnt;
        w_ptr_nxt   = r_ptr;
        w_grant_nxt = r_grant;
        w_err_nxt   = 1'b0;
        w_busy_nxt  = r_busy;
        w_ready     = {NREQ{1'b0}};
        case (r_state)
            ST_IDLE: begin
                if (w_any) begin
                    w_ready     = NREQ'(1'b1) << w_win;
                    w_grant_nxt = w_win;
                    w_ptr_nxt   = (w_win == 3'(NREQ - 1)) ? 3'd0 : (w_win + 3'd1);
                    if (w_bad) begin
                        w_err_nxt = 1'b1;
                    end else begin
                        w_state_nxt = ST_DRIVE;
                        w_busy_nxt  = 1'b1;
                        w_cnt_nxt   = 4'(HOLD - 1);
                        case (w_op)
                            2'b01: w_s_nxt = w_onehot;
                            2'b10: w_r_nxt = w_onehot;
                            2'b11: begin
                                if (w_qbit) begin
                                    w_r_nxt = w_onehot;
                                end else begin
                                    w_s_nxt = w_onehot;
                                end
                            end
                            default: begin
                                w_s_nxt = {NBITS{1'b0}};
                                w_r_nxt = {NBITS{1'b0}};
                            end
                        endcase
                    end
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_DRIVE: begin
                if (r_cnt == 4'd0) begin
                    w_state_nxt = ST_GAP;
                    w_s_nxt     = {NBITS{1'b0}};
                    w_r_nxt     = {NBITS{1'b0}};
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end
            end
            ST_GAP: begin
                w_state_nxt = ST_IDLE;
                w_busy_nxt  = 1'b0;
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_s_nxt     = {NBITS{1'b0}};
                w_r_nxt     = {NBITS{1'b0}};
                w_cnt_nxt   = 4'd0;
                w_busy_nxt  = 1'b0;
            end
        endcase
    end

    // State and output registers; reset drops S/R immediately and discards the command.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_s     <= {NBITS{1'b0}};
            r_r     <= {NBITS{1'b0}};
            r_cnt   <= 4'd0;
            r_ptr   <= 3'd0;
            r_grant <= 3'd0;
            r_err   <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_s     <= w_s_nxt;
            r_r     <= w_r_nxt;
            r_cnt   <= w_cnt_nxt;
            r_ptr   <= w_ptr_nxt;
            r_grant <= w_grant_nxt;
            r_err   <= w_err_nxt;
            r_busy  <= w_busy_nxt;
        end
    end

    assign req_if.req_ready = rst_n ? w_ready : {NREQ{1'b0}};
    assign s_out            = r_s;
    assign r_out            = r_r;
    assign busy             = r_busy;
    assign grant_id         = r_grant;
    assign err              = r_err;
endmodule

// File: tb/tb_sr_cmd_arbiter.sv
// Directed and random bench for sr_cmd_arbiter with a behavioural SR bank on q_fb.
module tb_sr_cmd_arbiter;
    localparam int NREQ  = 4;
    localparam int NBITS = 8;
    localparam int IDX_W = 4;
    localparam int HOLD  = 2;

    logic             clk   = 1'b0;
    logic             rst_n = 1'b1;
    logic [NBITS-1:0] bank  = 8'h00;
    logic [NBITS-1:0] s_out, r_out, exp_bank;
    logic             busy, err;
    logic [2:0]       grant_id;
    logic [NREQ-1:0]  hs, hs_prev;
    int               n_chk  = 0;
    int               n_pass = 0;

    sr_cmd_arbiter_if #(.NREQ(NREQ), .IDX_W(IDX_W)) rif ();

    sr_cmd_arbiter #(.NREQ(NREQ), .NBITS(NBITS), .IDX_W(IDX_W), .HOLD(HOLD)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req_if   (rif),
        .q_fb     (bank),
        .s_out    (s_out),
        .r_out    (r_out),
        .busy     (busy),
        .grant_id (grant_id),
        .err      (err)
    );

    always #5 clk = ~clk;

    // SR flip-flop bank fed by the arbiter.
    always @(posedge clk) bank <= (bank | s_out) & ~r_out;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic present(input int r, input logic [1:0] op, input logic [3:0] idx);
        rif.req_valid[r]        = 1'b1;
        rif.req_op[2*r +: 2]    = op;
        rif.req_idx[IDX_W*r +: IDX_W] = idx;
    endtask

    // Present a command, wait (bounded) for ready, return at negedge+1 of first pulse cycle.
    task automatic send(input int r, input logic [1:0] op, input logic [3:0] idx);
        int n = 0;
        present(r, op, idx);
        #1;
        while (!rif.req_ready[r] && n < 40) begin
            @(negedge clk); #1;
            n++;
        end
        check("accept_wait", {31'd0, rif.req_ready[r]}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        rif.req_valid[r] = 1'b0;
        #1;
    endtask

    task automatic drain();
        int n = 0;
        while (busy && n < 40) begin
            @(negedge clk); #1;
            n++;
        end
        check("drain", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        int ids[$];
        int cycs[$];
        int w;
        logic [1:0] op;
        logic [3:0] idx;

        rif.req_valid = 4'b0000;
        rif.req_op    = 8'h00;
        rif.req_idx   = 16'h0000;

        // Reset state
        #1 rst_n = 1'b0;
        #1;
        rif.req_valid = 4'b1111;
        #1;
        check("rst_s", {24'd0, s_out}, 32'h0);
        check("rst_r", {24'd0, r_out}, 32'h0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        check("rst_grant", {29'd0, grant_id}, 32'd0);
        check("rst_ready", {28'd0, rif.req_ready}, 32'h0);
        rif.req_valid = 4'b0000;
        @(negedge clk);
        rst_n = 1'b1;
        #1;

        // Set: req0 op=01 idx=5
        send(0, 2'b01, 4'd5);
        check("set_grant", {29'd0, grant_id}, 32'd0);
        for (int h = 0; h < HOLD; h++) begin
            check("set_s", {24'd0, s_out}, 32'h20);
            check("set_r", {24'd0, r_out}, 32'h00);
            check("set_busy", {31'd0, busy}, 32'd1);
            @(negedge clk); #1;
        end
        check("gap_s", {24'd0, s_out}, 32'h00);
        check("gap_r", {24'd0, r_out}, 32'h00);
        check("gap_busy", {31'd0, busy}, 32'd1);
        @(negedge clk); #1;
        check("idle_busy", {31'd0, busy}, 32'd0);
        check("bank_set5", {24'd0, bank}, 32'h20);

        // Toggle on bit 2, from 1 then from 0
        send(1, 2'b01, 4'd2);
        drain();
        check("bank_set2", {24'd0, bank}, 32'h24);
        send(1, 2'b11, 4'd2);
        check("tog1_r", {24'd0, r_out}, 32'h04);
        check("tog1_s", {24'd0, s_out}, 32'h00);
        check("tog1_grant", {29'd0, grant_id}, 32'd1);
        drain();
        check("bank_tog1", {24'd0, bank}, 32'h20);
        send(1, 2'b11, 4'd2);
        check("tog0_s", {24'd0, s_out}, 32'h04);
        check("tog0_r", {24'd0, r_out}, 32'h00);
        drain();
        check("bank_tog0", {24'd0, bank}, 32'h24);

        // Reset mid-DRIVE
        send(2, 2'b01, 4'd7);
        check("pre_rst_s", {24'd0, s_out}, 32'h80);
        #1 rst_n = 1'b0;
        #1;
        check("midrst_s", {24'd0, s_out}, 32'h00);
        check("midrst_r", {24'd0, r_out}, 32'h00);
        check("midrst_busy", {31'd0, busy}, 32'd0);
        rif.req_valid = 4'b1111;
        #1;
        check("midrst_ready", {28'd0, rif.req_ready}, 32'h0);
        rif.req_valid = 4'b0000;
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk); #1;
            check("no_replay", {24'd0, s_out | r_out}, 32'h00);
        end

        // Round-robin with all four valid continuously
        for (int i = 0; i < NREQ; i++) present(i, 2'b01, 4'(i));
        #1;
        for (int c = 0; c < 40 && ids.size() < 5; c++) begin
            if (rif.req_ready != 4'b0000) begin
                w = -1;
                for (int b = 0; b < NREQ; b++) if (rif.req_ready[b]) w = b;
                check("rr_onehot", {31'd0, $onehot(rif.req_ready)}, 32'd1);
                ids.push_back(w);
                cycs.push_back(c);
            end
            @(negedge clk); #1;
        end
        check("rr_count", ids.size(), 32'd5);
        for (int k = 0; k < ids.size(); k++) begin
            check("rr_grant", ids[k], k % NREQ);
            if (k > 0) check("rr_space", cycs[k] - cycs[k-1], HOLD + 2);
        end
        check("rr_grant_id", {29'd0, grant_id}, 32'd0);
        rif.req_valid = 4'b0000;
        drain();

        // Errors: illegal op, then idx out of range on the very next cycle
        present(2, 2'b00, 4'd1);
        #1;
        check("err1_ready", {28'd0, rif.req_ready}, 32'b0100);
        @(posedge clk);
        @(negedge clk);
        rif.req_valid[2] = 1'b0;
        present(3, 2'b01, 4'd9);
        #1;
        check("err1_pulse", {31'd0, err}, 32'd1);
        check("err1_busy", {31'd0, busy}, 32'd0);
        check("err1_sr", {24'd0, s_out | r_out}, 32'h00);
        check("err2_ready", {28'd0, rif.req_ready}, 32'b1000);
        @(posedge clk);
        @(negedge clk);
        rif.req_valid[3] = 1'b0;
        #1;
        check("err2_pulse", {31'd0, err}, 32'd1);
        check("err2_busy", {31'd0, busy}, 32'd0);
        check("err2_sr", {24'd0, s_out | r_out}, 32'h00);
        @(negedge clk); #1;
        check("err_clear", {31'd0, err}, 32'd0);
        check("err_bank", {24'd0, bank}, 32'h2f);

        // Random traffic against a command-level model of the bank
        exp_bank = bank;
        hs_prev  = 4'b0000;
        for (int cyc = 0; cyc < 10000; cyc++) begin
            @(negedge clk);
            for (int i = 0; i < NREQ; i++) begin
                if (hs_prev[i]) rif.req_valid[i] = 1'b0;
                else if (!rif.req_valid[i] && $urandom_range(0, 3) == 0)
                    present(i, 2'($urandom_range(0, 3)), 4'($urandom_range(0, 9)));
            end
            #1;
            hs = rif.req_valid & rif.req_ready;
            check("rnd_ready_oh", {31'd0, $onehot0(rif.req_ready)}, 32'd1);
            check("rnd_no_sr", {24'd0, s_out & r_out}, 32'h00);
            check("rnd_oh_sr", {31'd0, $onehot0(s_out | r_out)}, 32'd1);
            for (int i = 0; i < NREQ; i++) begin
                if (hs[i]) begin
                    op  = rif.req_op[2*i +: 2];
                    idx = rif.req_idx[IDX_W*i +: IDX_W];
                    if (op != 2'b00 && idx < 4'd8) begin
                        case (op)
                            2'b01:   exp_bank[idx[2:0]] = 1'b1;
                            2'b10:   exp_bank[idx[2:0]] = 1'b0;
                            default: exp_bank[idx[2:0]] = ~exp_bank[idx[2:0]];
                        endcase
                    end
                end
            end
            hs_prev = hs;
        end
        @(negedge clk);
        rif.req_valid = 4'b0000;
        #1;
        drain();
        check("rnd_bank", {24'd0, bank}, {24'd0, exp_bank});

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
